// File: rtl/control_pkg.sv
// Shared encodings for the SPARC V8 teaching-core control unit: states, opcode fields,
// ALU pass codes, datapath select values, trap causes and the instruction dispatch helper.
package control_pkg;

  typedef enum logic [3:0] {
    S_RESET, S_FETCH0, S_FETCH1, S_FETCH2, S_DECODE,
    S_ALU, S_SETHI, S_BRANCH,
    S_LD0, S_LD1, S_LD2,
    S_ST0, S_ST1, S_ST2,
    S_TRAP
  } state_t;

  localparam logic [1:0] OP_FMT2 = 2'b00;
  localparam logic [1:0] OP_CALL = 2'b01;
  localparam logic [1:0] OP_ALU  = 2'b10;
  localparam logic [1:0] OP_MEM  = 2'b11;

  localparam logic [2:0] OP2_SETHI = 3'b100;
  localparam logic [2:0] OP2_BICC  = 3'b010;
  localparam logic [5:0] OP3_LD    = 6'b000000;
  localparam logic [5:0] OP3_ST    = 6'b000100;

  localparam logic [5:0] ADD   = 6'b000000;
  localparam logic [5:0] PASSA = 6'b101110;
  localparam logic [5:0] PASSB = 6'b101111;

  localparam logic [1:0] EXT_SIMM13 = 2'b00;
  localparam logic [1:0] EXT_DISP22 = 2'b01;
  localparam logic [1:0] EXT_DISP30 = 2'b10;
  localparam logic [1:0] EXT_IMM22  = 2'b11;

  localparam logic [1:0] ALUA_PA  = 2'b00;
  localparam logic [1:0] ALUA_PC  = 2'b01;
  localparam logic [1:0] ALUA_NPC = 2'b10;

  localparam logic [1:0] ALUB_PB   = 2'b00;
  localparam logic [1:0] ALUB_EXT  = 2'b01;
  localparam logic [1:0] ALUB_MDR  = 2'b10;
  localparam logic [1:0] ALUB_ZERO = 2'b11;

  localparam logic [1:0] NPC_SEQ    = 2'b00;
  localparam logic [1:0] NPC_BRANCH = 2'b01;

  localparam logic [1:0] TRAP_NONE        = 2'b00;
  localparam logic [1:0] TRAP_ILLEGAL     = 2'b01;
  localparam logic [1:0] TRAP_MEM_TIMEOUT = 2'b10;

  // CALL and every unsupported encoding fall through to the illegal-instruction trap.
  function automatic state_t decode_next(input logic [31:0] ir);
    state_t nxt;
    nxt = S_TRAP;
    case (ir[31:30])
      OP_ALU:  if (!ir[24]) nxt = S_ALU;
      OP_FMT2: begin
        if (ir[24:22] == OP2_SETHI)     nxt = S_SETHI;
        else if (ir[24:22] == OP2_BICC) nxt = S_BRANCH;
      end
      OP_MEM: begin
        if (ir[24:19] == OP3_LD)      nxt = S_LD0;
        else if (ir[24:19] == OP3_ST) nxt = S_ST0;
      end
      default: nxt = S_TRAP;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Evaluates a Bicc condition field against the PSR icc flags {N,Z,V,C}.
// Purely combinational, zero latency; no flow control.
module branch_cond_eval
  import control_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] icc,
  output logic       taken
);
  logic n, z, v, c;
  assign {n, z, v, c} = icc;

  always_comb begin
    taken = 1'b0;
    case (cond)
      4'b1000: taken = 1'b1;
      4'b0000: taken = 1'b0;
      4'b1001: taken = !z;
      4'b0001: taken = z;
      4'b1010: taken = !(z | (n ^ v));
      4'b0010: taken = z | (n ^ v);
      4'b1011: taken = !(n ^ v);
      4'b0011: taken = n ^ v;
      4'b1100: taken = !(c | z);
      4'b0100: taken = c | z;
      4'b1101: taken = !c;
      4'b0101: taken = c;
      4'b1110: taken = !n;
      4'b0110: taken = n;
      4'b1111: taken = !v;
      4'b0111: taken = v;
      default: taken = 1'b0;
    endcase
  end
endmodule

// File: rtl/control_unit.sv
// FSM sequencer driving every datapath enable/select; 5 cycles for ALU/SETHI/Bicc, 7 for LD/ST.
// Stalls in FETCH1/LD1/ST2 until MFC, trapping after MFC_TIMEOUT idle wait cycles.
module control_unit
  import control_pkg::*;
#(
  parameter int MFC_TIMEOUT = 15
) (
  input  logic        Clk,
  input  logic        Clr,
  input  logic [31:0] IR_Out,
  input  logic        MFC,
  input  logic [3:0]  icc,
  output logic        NPC_enable,
  output logic        PC_enable,
  output logic        IR_Enable,
  output logic        MDR_Enable,
  output logic        MAR_Enable,
  output logic        file_enable,
  output logic        PSR_Enable,
  output logic        RAM_enable,
  output logic        RAM_OpCode,
  output logic [1:0]  extender_select,
  output logic        MDR_Mux_select,
  output logic [1:0]  ALUA_Mux_select,
  output logic [1:0]  ALUB_Mux_select,
  output logic        RB_sel,
  output logic [1:0]  NPC_sel,
  output logic [5:0]  ALU_op,
  output logic        trap,
  output logic [1:0]  trap_type
);
  localparam int CW = $clog2(MFC_TIMEOUT + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(MFC_TIMEOUT - 1);

  state_t        state;
  state_t        wait_exit;
  logic [CW-1:0] wait_cnt;
  logic [1:0]    trap_type_q;
  logic          br_taken;
  logic          wait_expired;
  wire           unused_ir = &{1'b0, IR_Out[29], IR_Out[18:14], IR_Out[12:0]};

  branch_cond_eval u_bcond (
    .cond  (IR_Out[28:25]),
    .icc   (icc),
    .taken (br_taken)
  );

  // This idle cycle is the one that brings the count up to MFC_TIMEOUT.
  assign wait_expired = (wait_cnt == WAIT_LAST);

  always_comb begin
    wait_exit = S_FETCH0;
    case (state)
      S_FETCH1: wait_exit = S_FETCH2;
      S_LD1:    wait_exit = S_LD2;
      default:  wait_exit = S_FETCH0;
    endcase
  end

  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      state       <= S_RESET;
      wait_cnt    <= '0;
      trap_type_q <= TRAP_NONE;
    end else begin
      case (state)
        S_FETCH1, S_LD1, S_ST2: begin
          if (MFC) begin
            state <= wait_exit;
          end else if (wait_expired) begin
            state       <= S_TRAP;
            trap_type_q <= TRAP_MEM_TIMEOUT;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: begin
          wait_cnt <= '0;
          case (state)
            S_RESET:  state <= S_FETCH0;
            S_FETCH0: state <= S_FETCH1;
            S_FETCH2: state <= S_DECODE;
            S_DECODE: begin
              state <= decode_next(IR_Out);
              if (decode_next(IR_Out) == S_TRAP) trap_type_q <= TRAP_ILLEGAL;
            end
            S_LD0:    state <= S_LD1;
            S_ST0:    state <= S_ST1;
            S_ST1:    state <= S_ST2;
            S_TRAP:   state <= S_TRAP;
            default:  state <= S_FETCH0;
          endcase
        end
      endcase
    end
  end

  always_comb begin
    NPC_enable      = 1'b0;
    PC_enable       = 1'b0;
    IR_Enable       = 1'b0;
    MDR_Enable      = 1'b0;
    MAR_Enable      = 1'b0;
    file_enable     = 1'b0;
    PSR_Enable      = 1'b0;
    RAM_enable      = 1'b0;
    RAM_OpCode      = 1'b0;
    extender_select = EXT_SIMM13;
    MDR_Mux_select  = 1'b0;
    ALUA_Mux_select = ALUA_PA;
    ALUB_Mux_select = ALUB_PB;
    RB_sel          = 1'b0;
    NPC_sel         = NPC_SEQ;
    ALU_op          = ADD;
    trap            = 1'b0;
    trap_type       = trap_type_q;
    case (state)
      S_FETCH0: begin
        ALUA_Mux_select = ALUA_PC;
        ALU_op          = PASSA;
        MAR_Enable      = 1'b1;
      end
      S_FETCH1: begin
        RAM_enable = 1'b1;
        RAM_OpCode = 1'b1;
        IR_Enable  = MFC;
      end
      S_FETCH2: begin
        PC_enable  = 1'b1;
        NPC_enable = 1'b1;
      end
      S_ALU: begin
        ALU_op          = IR_Out[24:19];
        ALUB_Mux_select = IR_Out[13] ? ALUB_EXT : ALUB_PB;
        file_enable     = 1'b1;
        PSR_Enable      = IR_Out[23];
      end
      S_SETHI: begin
        extender_select = EXT_IMM22;
        ALUB_Mux_select = ALUB_EXT;
        ALU_op          = PASSB;
        file_enable     = 1'b1;
      end
      S_BRANCH: begin
        extender_select = EXT_DISP22;
        NPC_enable      = br_taken;
        NPC_sel         = br_taken ? NPC_BRANCH : NPC_SEQ;
      end
      S_LD0, S_ST0: begin
        ALUB_Mux_select = IR_Out[13] ? ALUB_EXT : ALUB_PB;
        MAR_Enable      = 1'b1;
      end
      S_LD1: begin
        RAM_enable     = 1'b1;
        RAM_OpCode     = 1'b1;
        MDR_Mux_select = 1'b1;
        MDR_Enable     = MFC;
      end
      S_LD2: begin
        ALUB_Mux_select = ALUB_MDR;
        ALU_op          = PASSB;
        file_enable     = 1'b1;
      end
      S_ST1: begin
        RB_sel     = 1'b1;
        ALU_op     = PASSB;
        MDR_Enable = 1'b1;
      end
      S_ST2:   RAM_enable = 1'b1;
      S_TRAP:  trap = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_control_unit.sv
// Cycle-exact bench: each scenario queues per-cycle MFC stimulus and expected outputs,
// then drains the queue against the control unit one cycle at a time.
module tb_control_unit;
  logic        Clk, Clr, MFC;
  logic [31:0] IR_Out;
  logic [3:0]  icc;
  logic        NPC_enable, PC_enable, IR_Enable, MDR_Enable, MAR_Enable, file_enable, PSR_Enable;
  logic        RAM_enable, RAM_OpCode, MDR_Mux_select, RB_sel, trap;
  logic [1:0]  extender_select, ALUA_Mux_select, ALUB_Mux_select, NPC_sel, trap_type;
  logic [5:0]  ALU_op;

  typedef struct packed {
    logic npc_en, pc_en, ir_en, mdr_en, mar_en, file_en, psr_en, ram_en, ram_op;
    logic [1:0] ext;
    logic       mdr_mux;
    logic [1:0] alua, alub;
    logic       rb;
    logic [1:0] npc_sel;
    logic [5:0] alu_op;
    logic       trap;
    logic [1:0] trap_type;
  } out_t;

  typedef struct {
    logic  mfc;
    out_t  exp;
    string tag;
  } step_t;

  step_t sb[$];
  out_t  act;
  int    n_pass = 0;
  int    n_total = 0;

  assign act = {NPC_enable, PC_enable, IR_Enable, MDR_Enable, MAR_Enable, file_enable, PSR_Enable,
                RAM_enable, RAM_OpCode, extender_select, MDR_Mux_select, ALUA_Mux_select,
                ALUB_Mux_select, RB_sel, NPC_sel, ALU_op, trap, trap_type};

  control_unit #(.MFC_TIMEOUT(15)) dut (
    .Clk(Clk), .Clr(Clr), .IR_Out(IR_Out), .MFC(MFC), .icc(icc),
    .NPC_enable(NPC_enable), .PC_enable(PC_enable), .IR_Enable(IR_Enable),
    .MDR_Enable(MDR_Enable), .MAR_Enable(MAR_Enable), .file_enable(file_enable),
    .PSR_Enable(PSR_Enable), .RAM_enable(RAM_enable), .RAM_OpCode(RAM_OpCode),
    .extender_select(extender_select), .MDR_Mux_select(MDR_Mux_select),
    .ALUA_Mux_select(ALUA_Mux_select), .ALUB_Mux_select(ALUB_Mux_select),
    .RB_sel(RB_sel), .NPC_sel(NPC_sel), .ALU_op(ALU_op), .trap(trap), .trap_type(trap_type)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1);
  end

  task automatic push(input logic mfc, input out_t e, input string tag);
    step_t s;
    s.mfc = mfc;
    s.exp = e;
    s.tag = tag;
    sb.push_back(s);
  endtask

  // Fetch/decode expectations with `delay` idle MFC cycles before the instruction arrives.
  task automatic push_fetch(input int delay);
    out_t e;
    e = '0; e.alua = 2'b01; e.alu_op = 6'b101110; e.mar_en = 1'b1;
    push(1'b0, e, "fetch0");
    e = '0; e.ram_en = 1'b1; e.ram_op = 1'b1;
    for (int i = 0; i < delay; i++) push(1'b0, e, "fetch1_wait");
    e.ir_en = 1'b1;
    push(1'b1, e, "fetch1_done");
    e = '0; e.pc_en = 1'b1; e.npc_en = 1'b1;
    push(1'b0, e, "fetch2");
    e = '0;
    push(1'b0, e, "decode");
  endtask

  task automatic push_addr(input string tag);
    out_t e;
    e = '0; e.alub = 2'b01; e.mar_en = 1'b1;
    push(1'b0, e, tag);
  endtask

  // Pops one step, drives its MFC and samples the outputs between clock edges.
  task automatic step_dut(output step_t s, output out_t a);
    s = sb.pop_front();
    @(negedge Clk);
    MFC = s.mfc;
    #1;
    a = act;
  endtask

  task automatic pulse_clr();
    @(negedge Clk);
    Clr = 1'b0;
    MFC = 1'b0;
    #1;
    @(negedge Clk);
    Clr = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    Clr = 1'b0; MFC = 1'b0; IR_Out = 32'h0; icc = 4'h0;
    #3;
    n_total++;
    if (act !== out_t'(0)) $display("FAIL reset_low: outputs %h, required %h", act, out_t'(0));
    else n_pass++;
    @(negedge Clk);
    Clr = 1'b1;
    #1;
    n_total++;
    if (act !== out_t'(0)) $display("FAIL reset_state: outputs %h, required %h", act, out_t'(0));
    else n_pass++;
  endtask

  task automatic test_alu_add();
    step_t s; out_t a, e;
    IR_Out = 32'h86004002; icc = 4'h0;
    push_fetch(2);
    e = '0; e.file_en = 1'b1;
    push(1'b0, e, "alu_add");
    while (sb.size() > 0) begin
      step_dut(s, a);
      n_total++;
      if (a !== s.exp) $display("FAIL add_%s: outputs %h, required %h", s.tag, a, s.exp);
      else n_pass++;
    end
  endtask

  task automatic test_alu_addcc();
    step_t s; out_t a, e;
    IR_Out = 32'h86806005;
    push_fetch(0);
    e = '0; e.alu_op = 6'b010000; e.alub = 2'b01; e.file_en = 1'b1; e.psr_en = 1'b1;
    push(1'b0, e, "alu_addcc");
    while (sb.size() > 0) begin
      step_dut(s, a);
      n_total++;
      if (a !== s.exp) $display("FAIL addcc_%s: outputs %h, required %h", s.tag, a, s.exp);
      else n_pass++;
    end
  endtask

  task automatic test_branch();
    step_t s; out_t a, e;
    IR_Out = 32'h02800004;
    for (int k = 0; k < 2; k++) begin
      icc = (k == 0) ? 4'b0100 : 4'b0000;
      push_fetch(1);
      e = '0; e.ext = 2'b01;
      if (k == 0) begin e.npc_en = 1'b1; e.npc_sel = 2'b01; end
      push(1'b0, e, (k == 0) ? "be_taken" : "be_not_taken");
      while (sb.size() > 0) begin
        step_dut(s, a);
        n_total++;
        if (a !== s.exp) $display("FAIL branch_%s: outputs %h, required %h", s.tag, a, s.exp);
        else n_pass++;
      end
    end
  endtask

  task automatic test_sethi();
    step_t s; out_t a, e;
    IR_Out = 32'h03000010;
    push_fetch(0);
    e = '0; e.ext = 2'b11; e.alub = 2'b01; e.alu_op = 6'b101111; e.file_en = 1'b1;
    push(1'b0, e, "sethi");
    while (sb.size() > 0) begin
      step_dut(s, a);
      n_total++;
      if (a !== s.exp) $display("FAIL sethi_%s: outputs %h, required %h", s.tag, a, s.exp);
      else n_pass++;
    end
  endtask

  // LD whose data arrives on the 15th wait cycle, exactly when the counter would expire.
  task automatic test_ld_mfc_wins();
    step_t s; out_t a, e;
    IR_Out = 32'hC2002004;
    push_fetch(0);
    push_addr("ld0");
    e = '0; e.ram_en = 1'b1; e.ram_op = 1'b1; e.mdr_mux = 1'b1;
    for (int i = 0; i < 14; i++) push(1'b0, e, "ld1_wait");
    e.mdr_en = 1'b1;
    push(1'b1, e, "ld1_done");
    e = '0; e.alub = 2'b10; e.alu_op = 6'b101111; e.file_en = 1'b1;
    push(1'b0, e, "ld2");
    while (sb.size() > 0) begin
      step_dut(s, a);
      n_total++;
      if (a !== s.exp) $display("FAIL ld_%s: outputs %h, required %h", s.tag, a, s.exp);
      else n_pass++;
    end
  endtask

  task automatic test_st();
    step_t s; out_t a, e;
    IR_Out = 32'hC2202004;
    push_fetch(0);
    push_addr("st0");
    e = '0; e.rb = 1'b1; e.alu_op = 6'b101111; e.mdr_en = 1'b1;
    push(1'b0, e, "st1");
    e = '0; e.ram_en = 1'b1;
    push(1'b0, e, "st2_wait");
    push(1'b1, e, "st2_done");
    while (sb.size() > 0) begin
      step_dut(s, a);
      n_total++;
      if (a !== s.exp) $display("FAIL st_%s: outputs %h, required %h", s.tag, a, s.exp);
      else n_pass++;
    end
  endtask

  task automatic test_clr_mid_wait();
    step_t s; out_t a, e;
    IR_Out = 32'hC2002004;
    push_fetch(0);
    push_addr("ld0");
    e = '0; e.ram_en = 1'b1; e.ram_op = 1'b1; e.mdr_mux = 1'b1;
    push(1'b0, e, "ld1_wait");
    while (sb.size() > 0) begin
      step_dut(s, a);
      n_total++;
      if (a !== s.exp) $display("FAIL clrwait_%s: outputs %h, required %h", s.tag, a, s.exp);
      else n_pass++;
    end
    Clr = 1'b0;
    #1;
    n_total++;
    if (act !== out_t'(0)) $display("FAIL clr_async: outputs %h, required %h", act, out_t'(0));
    else n_pass++;
    @(negedge Clk);
    Clr = 1'b1;
    #1;
    n_total++;
    if (act !== out_t'(0)) $display("FAIL clr_release: outputs %h, required %h", act, out_t'(0));
    else n_pass++;
    e = '0; e.alua = 2'b01; e.alu_op = 6'b101110; e.mar_en = 1'b1;
    push(1'b0, e, "fetch0_after_clr");
    step_dut(s, a);
    n_total++;
    if (a !== s.exp) $display("FAIL clrwait_%s: outputs %h, required %h", s.tag, a, s.exp);
    else n_pass++;
    pulse_clr();
  endtask

  task automatic test_timeout();
    step_t s; out_t a, e;
    IR_Out = 32'hC2002004;
    push_fetch(0);
    push_addr("ld0");
    e = '0; e.ram_en = 1'b1; e.ram_op = 1'b1; e.mdr_mux = 1'b1;
    for (int i = 0; i < 15; i++) push(1'b0, e, "ld1_wait");
    e = '0; e.trap = 1'b1; e.trap_type = 2'b10;
    push(1'b0, e, "trap");
    push(1'b1, e, "trap_mfc");
    push(1'b0, e, "trap_hold");
    while (sb.size() > 0) begin
      step_dut(s, a);
      n_total++;
      if (a !== s.exp) $display("FAIL timeout_%s: outputs %h, required %h", s.tag, a, s.exp);
      else n_pass++;
    end
    pulse_clr();
    n_total++;
    if (act !== out_t'(0)) $display("FAIL timeout_cleared: outputs %h, required %h", act, out_t'(0));
    else n_pass++;
  endtask

  task automatic test_illegal();
    step_t s; out_t a, e;
    IR_Out = 32'h40000000;
    push_fetch(0);
    e = '0; e.trap = 1'b1; e.trap_type = 2'b01;
    for (int i = 0; i < 4; i++) push(i[0], e, "call_trap");
    while (sb.size() > 0) begin
      step_dut(s, a);
      n_total++;
      if (a !== s.exp) $display("FAIL illegal_%s: outputs %h, required %h", s.tag, a, s.exp);
      else n_pass++;
    end
    pulse_clr();
    n_total++;
    if (act !== out_t'(0)) $display("FAIL illegal_cleared: outputs %h, required %h", act, out_t'(0));
    else n_pass++;
  endtask

  // Back-to-back: an ALU op straight after recovery from a trap.
  task automatic test_back_to_back();
    step_t s; out_t a, e;
    IR_Out = 32'h86004002;
    push_fetch(0);
    e = '0; e.file_en = 1'b1;
    push(1'b0, e, "alu_after_trap");
    while (sb.size() > 0) begin
      step_dut(s, a);
      n_total++;
      if (a !== s.exp) $display("FAIL b2b_%s: outputs %h, required %h", s.tag, a, s.exp);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_alu_add();
    test_alu_addcc();
    test_branch();
    test_sethi();
    test_ld_mfc_wins();
    test_st();
    test_clr_mid_wait();
    test_timeout();
    test_illegal();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
